// File: rtl/afifo_pkg.sv
// Shared types and default constants for the afifo write-side arbiter slice.
package afifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int AFIFO_DSIZE = 8;
  localparam int AFIFO_ASIZE = 4;
  localparam int ARB_BURST   = 4;

endpackage

// File: rtl/afifo_wr_arb_if.sv
// Requester bundle plus the afifo write port, as seen by the write-side arbiter.
interface afifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

endinterface

// File: rtl/afifo_wr_arb_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward from last+1.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   idx
);

  int unsigned k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = (32'(last) + i) % NREQ;
      if (!found && req[IW'(k)]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter sharing the afifo write port among NREQ producers.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = AFIFO_DSIZE,
  parameter int BURST = ARB_BURST
) (
  input logic            clk,
  input logic            rst,
  afifo_wr_arb_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST) + 1;

  arb_state_t    state_q;
  logic [IW-1:0] grant_id_q;
  logic [IW-1:0] last_q;
  logic [CW-1:0] burst_cnt_q;
  logic          busy_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          g_valid;
  logic          wr;
  logic          burst_last;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Outputs are gated by rst so no transfer can happen on a reset edge.
  always_comb begin
    g_valid       = 1'b0;
    bus.req_ready = '0;
    bus.wdata     = '0;
    if (state_q == GRANT && !rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (IW'(i) == grant_id_q) begin
          g_valid          = bus.req_valid[i];
          bus.req_ready[i] = ~bus.wfull;
          bus.wdata        = bus.req_data[i*DSIZE +: DSIZE];
        end
      end
    end
  end

  assign wr           = g_valid & ~bus.wfull;
  assign burst_last   = (burst_cnt_q == CW'(BURST - 1));
  assign bus.winc     = wr;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_q      <= IW'(NREQ - 1);
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q  <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
            busy_q      <= 1'b1;
          end
        end
        GRANT: begin
          if (!g_valid || (wr && burst_last)) begin
            last_q  <= grant_id_q;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wr) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb with behavioural producers and a 16-deep FIFO fill model.
module tb_afifo_wr_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  afifo_wr_arb_if #(.NREQ(4), .DSIZE(8)) bus ();

  afifo_wr_arb #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int         rem [4];
  logic [7:0] nxt [4];
  int         fill;
  bit         drain;
  bit         rinc;

  logic [7:0] wlog_d [$];
  int         wlog_g [$];
  logic       tr_winc [$];
  logic       tr_busy [$];
  int         tr_gid [$];

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      bus.req_valid[k]       = (rem[k] > 0);
      bus.req_data[k*8 +: 8] = nxt[k];
    end
    bus.wfull = (fill >= 16);
  endtask

  // One clock: observe at negedge, update producers/FIFO model, re-drive after the edge.
  task automatic cycle();
    @(negedge clk);
    tr_winc.push_back(bus.winc);
    tr_busy.push_back(bus.busy);
    tr_gid.push_back(int'(bus.grant_id));
    if (bus.winc) begin
      wlog_d.push_back(bus.wdata);
      wlog_g.push_back(int'(bus.grant_id));
      fill++;
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.req_valid[k] && bus.req_ready[k]) begin
        rem[k]--;
        nxt[k] = nxt[k] + 8'd1;
      end
    end
    if ((rinc || drain) && fill > 0) fill--;
    rinc = 1'b0;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until(input int n, input int budget, output int used);
    used = 0;
    while (wlog_d.size() < n && used < budget) begin
      cycle();
      used++;
    end
  endtask

  task automatic init_env();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rem[k] = 0;
      nxt[k] = 8'h00;
    end
    fill  = 0;
    drain = 1'b0;
    rinc  = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wlog_d.delete();
    wlog_g.delete();
    tr_winc.delete();
    tr_busy.delete();
    tr_gid.delete();
  endtask

  task automatic test_reset();
    init_env();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) rem[k] = 4;
    drive();
    #1;
    checks++;
    if (bus.winc !== 1'b0) begin
      errors++; $display("FAIL reset_winc_during_rst: got %b exp 0", bus.winc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_grant_id: got %0d exp 0", bus.grant_id);
    end
    checks++;
    if (bus.winc !== 1'b0) begin
      errors++; $display("FAIL reset_winc: got %b exp 0", bus.winc);
    end
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b exp 0000", bus.req_ready);
    end
    checks++;
    if (bus.wdata !== 8'h00) begin
      errors++; $display("FAIL reset_wdata: got %h exp 00", bus.wdata);
    end
  endtask

  task automatic test_single();
    logic [9:0] got;
    init_env();
    rem[0] = 8;
    nxt[0] = 8'h00;
    drive();
    repeat (12) cycle();
    for (int i = 0; i < 10; i++) got[9-i] = tr_winc[i];
    checks++;
    if (got !== 10'b0111101111) begin
      errors++; $display("FAIL single_winc_pattern: got %b exp 0111101111", got);
    end
    checks++;
    if (wlog_d.size() != 8) begin
      errors++; $display("FAIL single_count: got %0d exp 8", wlog_d.size());
    end
    for (int i = 0; i < 8 && i < wlog_d.size(); i++) begin
      checks++;
      if (wlog_d[i] !== 8'(i) || wlog_g[i] != 0) begin
        errors++; $display("FAIL single_word%0d: got %h/g%0d exp %h/g0", i, wlog_d[i], wlog_g[i], 8'(i));
      end
    end
  endtask

  task automatic test_round_robin();
    int used;
    int burst, k, j;
    logic [7:0] exp_d;
    init_env();
    drain = 1'b1;
    for (int q = 0; q < 4; q++) begin
      rem[q] = 8;
      nxt[q] = {4'(q), 4'h0};
    end
    drive();
    run_until(32, 100, used);
    checks++;
    if (used != 40) begin
      errors++; $display("FAIL rr_cycles: got %0d exp 40", used);
    end
    for (int i = 0; i < 32 && i < wlog_d.size(); i++) begin
      burst = i / 4;
      k     = burst % 4;
      j     = (burst / 4) * 4 + (i % 4);
      exp_d = {4'(k), 4'(j)};
      checks++;
      if (wlog_d[i] !== exp_d || wlog_g[i] != k) begin
        errors++; $display("FAIL rr_word%0d: got %h/g%0d exp %h/g%0d", i, wlog_d[i], wlog_g[i], exp_d, k);
      end
    end
  endtask

  task automatic test_full_stall();
    init_env();
    rem[1] = 20;
    nxt[1] = 8'h40;
    drive();
    repeat (30) cycle();
    checks++;
    if (wlog_d.size() != 16) begin
      errors++; $display("FAIL stall_count: got %0d exp 16", wlog_d.size());
    end
    checks++;
    if ({bus.wfull, bus.winc, bus.busy} !== 3'b101 || bus.req_ready !== 4'b0000 || bus.grant_id !== 2'd1) begin
      errors++; $display("FAIL stall_hold: got full%b winc%b busy%b rdy%b g%0d exp full1 winc0 busy1 rdy0000 g1",
                         bus.wfull, bus.winc, bus.busy, bus.req_ready, bus.grant_id);
    end
    rinc = 1'b1;
    repeat (6) cycle();
    checks++;
    if (wlog_d.size() != 17) begin
      errors++; $display("FAIL stall_one_more: got %0d exp 17", wlog_d.size());
    end
    checks++;
    if (wlog_d.size() < 17 || wlog_d[16] !== 8'h50) begin
      errors++; $display("FAIL stall_word16: got %h exp 50", (wlog_d.size() > 16) ? wlog_d[16] : 8'hxx);
    end
    checks++;
    if (bus.winc !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL stall_rehold: got winc%b busy%b exp winc0 busy1", bus.winc, bus.busy);
    end
  endtask

  task automatic test_early_release();
    logic [8:0] got;
    logic [7:0] exp_d [6] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h33};
    int         exp_g [6] = '{2, 2, 3, 3, 3, 3};
    init_env();
    rem[2] = 2; nxt[2] = 8'h20;
    rem[3] = 4; nxt[3] = 8'h30;
    drive();
    repeat (10) cycle();
    for (int i = 0; i < 9; i++) got[8-i] = tr_winc[i];
    checks++;
    if (got !== 9'b011001111) begin
      errors++; $display("FAIL early_winc_pattern: got %b exp 011001111", got);
    end
    checks++;
    if (tr_busy[4] !== 1'b0 || tr_gid[5] != 3) begin
      errors++; $display("FAIL early_bubble: got busy%b g%0d exp busy0 then g3", tr_busy[4], tr_gid[5]);
    end
    checks++;
    if (wlog_d.size() != 6) begin
      errors++; $display("FAIL early_count: got %0d exp 6", wlog_d.size());
    end
    for (int i = 0; i < 6 && i < wlog_d.size(); i++) begin
      checks++;
      if (wlog_d[i] !== exp_d[i] || wlog_g[i] != exp_g[i]) begin
        errors++; $display("FAIL early_word%0d: got %h/g%0d exp %h/g%0d", i, wlog_d[i], wlog_g[i], exp_d[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int used;
    init_env();
    drain = 1'b1;
    for (int q = 0; q < 4; q++) begin
      rem[q] = 8;
      nxt[q] = {4'(q), 4'h0};
    end
    drive();
    run_until(2, 20, used);
    checks++;
    if (wlog_d.size() != 2) begin
      errors++; $display("FAIL rstmid_pre: got %0d exp 2 writes", wlog_d.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.winc !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL rstmid_winc: got winc%b rdy%b exp winc0 rdy0000", bus.winc, bus.req_ready);
    end
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (wlog_d.size() != 2) begin
      errors++; $display("FAIL rstmid_nowrite: got %0d exp 2", wlog_d.size());
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.winc !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got busy%b g%0d winc%b exp busy0 g0 winc0", bus.busy, bus.grant_id, bus.winc);
    end
    run_until(3, 10, used);
    checks++;
    if (wlog_d.size() < 3 || wlog_g[2] != 0 || wlog_d[2] !== 8'h02) begin
      errors++; $display("FAIL rstmid_regrant: got n%0d exp 3 writes, third from g0 with data 02", wlog_d.size());
    end
  endtask

  task automatic test_sparse();
    int used;
    int bad;
    int k;
    logic [7:0] exp_d;
    init_env();
    drain = 1'b1;
    rem[1] = 8; nxt[1] = 8'h10;
    rem[3] = 8; nxt[3] = 8'h30;
    drive();
    run_until(16, 60, used);
    checks++;
    if (wlog_d.size() != 16) begin
      errors++; $display("FAIL sparse_count: got %0d exp 16", wlog_d.size());
    end
    for (int i = 0; i < 16 && i < wlog_d.size(); i++) begin
      k     = ((i / 4) % 2 == 1) ? 3 : 1;
      exp_d = {4'(k), 4'((i / 8) * 4 + (i % 4))};
      checks++;
      if (wlog_d[i] !== exp_d || wlog_g[i] != k) begin
        errors++; $display("FAIL sparse_word%0d: got %h/g%0d exp %h/g%0d", i, wlog_d[i], wlog_g[i], exp_d, k);
      end
    end
    bad = 0;
    for (int i = 0; i < tr_busy.size(); i++)
      if (tr_busy[i] && (tr_gid[i] == 0 || tr_gid[i] == 2)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sparse_idle_grants: got %0d busy cycles on 0/2 exp 0", bad);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_sparse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arb.md
# afifo_wr_arb

Write-side arbiter that shares the single write port of `afifo` among `NREQ` producers in the write clock domain. Grants one requester at a time in round-robin order, holds the grant for a burst of up to `BURST` words, and drives `winc`/`wdata` of the FIFO directly. It never writes while `wfull` is high.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DSIZE`, 8, data width, equal to `afifo` `DSIZE`
- `BURST`, 4, maximum words per grant (1..16)
- `clk` in 1: write clock, the same clock as `afifo` `wclk`
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NREQ: per-requester data valid
- `req_data` in NREQ*DSIZE: requester k occupies bits [k*DSIZE +: DSIZE]
- `req_ready` out NREQ: one-hot or zero; a word transfers from requester k when `req_valid[k]` and `req_ready[k]` are both high at a clk edge
- `wfull` in 1: from `afifo`
- `winc` out 1: to `afifo` `winc`
- `wdata` out DSIZE: to `afifo` `wdata`
- `grant_id` out clog2(NREQ): index of the current or last grantee
- `busy` out 1: high in GRANT

## Operation
- FSM with two states.
  - IDLE:
    - If any `req_valid` is high, select the first requester with `req_valid` high, searching upward from `last+1` modulo NREQ.
    - Register the winner into `grant_id`, clear `burst_cnt`, go to GRANT.
    - If no requester is valid, stay in IDLE.
  - GRANT, with `g` = `grant_id`:
    - `req_ready[g] = ~wfull`. All other `req_ready` bits are 0.
    - `winc = req_valid[g] & ~wfull`.
    - `wdata = req_data[g]`.
- In GRANT, each cycle with `winc` high is one write. `burst_cnt` increments on each write.
- Release the grant, set `last <= g`, and go to IDLE when either:
  - a write occurs with `burst_cnt == BURST-1`, or
  - `req_valid[g]` is low, whatever the state of `wfull`.
- `wfull` high with `req_valid[g]` high is a stall. The grant is held, `burst_cnt` is unchanged, and there is no timeout.
- In IDLE, `winc` = 0, `req_ready` = 0, `wdata` = 0.
- `req_data` of a granted requester must be stable while its `req_valid` is high. A requester that drops `req_valid` loses the grant.

## Timing
- Reset values: state IDLE, `grant_id` 0, `last` NREQ-1 (requester 0 wins first), `burst_cnt` 0, `busy` 0, `winc` 0, `req_ready` 0, `wdata` 0.
- Reset asserted mid-burst: at that edge the block enters IDLE and applies all reset values. No write occurs in the reset cycle; `winc` is forced to 0 while `rst` is high.
- Arbitration latency is 1 cycle. A request seen in IDLE at edge n gives GRANT, with `winc` possible, in cycle n+1.
- Every release costs exactly one IDLE bubble cycle. Peak throughput is BURST/(BURST+1) words per cycle.
- `winc`, `wdata` and `req_ready` are combinational from the registered state, `grant_id`, `req_valid` and `wfull`. `wfull` is registered inside `afifo`, so there is no combinational loop.
- Wrap-around: after requester NREQ-1, the search resumes at 0.
- A requester that raises `req_valid` in the same cycle as a release is eligible in the following IDLE cycle.

## Structure
- Package `afifo_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT}
  - default constants `AFIFO_DSIZE` = 8, `AFIFO_ASIZE` = 4, `ARB_BURST` = 4
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req[NREQ]`, `last`.
  - Outputs: `found`, `idx`.
- `afifo_wr_arb` holds the FSM, `burst_cnt` (clog2(BURST)+1 bits), `grant_id`, `last` and the output muxes.
- The top-level wrapper instantiates `afifo_wr_arb` feeding `afifo`. `clk` ties to `wclk`; `wrst_n` is `~rst` for the bench.

## Test plan
- Single requester: `req_valid[0]` held high with data 0x00..0x07, BURST=4 → 4 writes, 1 IDLE cycle, 4 writes. `grant_id` stays 0. `afifo` reads back 0x00..0x07 in order.
- Round-robin fairness: all 4 requesters valid continuously, requester k sending 0xk0, 0xk1, … → grants in order 0,1,2,3,0. Exactly 4 words per grant. FIFO order is 00 01 02 03 10 11 12 13 20 …
- Full stall: FIFO depth 16 with the read side idle, requester 1 streaming 20 words → exactly 16 writes, then `wfull`=1, `winc`=0, `req_ready`=0, grant held. Pulsing `rinc` once → exactly one more write.
- Early release: requester 2 valid for 2 words only, requester 3 waiting → 2 writes from 2, 1 bubble, then grant to 3. `last`=2 is reflected by `grant_id`=3.
- Reset mid-burst: assert `rst` for 1 cycle after the second word of a burst → `winc`=0 in that cycle. Next cycle: IDLE, `grant_id`=0, `busy`=0. With all requesters valid, requester 0 is granted next.
- Sparse requests: only requesters 1 and 3 valid → grants alternate 1,3,1,3 with no cycles granted to 0 or 2.
